// File: rtl/ftps_stroke_ctrl.sv
// rtl/ftps_stroke_ctrl.sv - fingertip lock/track sequencer with pen-stroke point FIFO
// Optional FTPS_SMOOTH_EN: pushed TRACK points are averaged with the previous point.
module ftps_stroke_ctrl #(
   parameter int X_SIZE      = 320,
   parameter int Y_SIZE      = 240,
   parameter int ACQ_FRAMES  = 3,
   parameter int LOST_FRAMES = 4,
   parameter int JUMP_MAX    = 40,
   parameter int FIFO_DEPTH  = 16,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic          vsync,
   input  logic          enable,
   input  logic          ftps_valid,
   input  logic [8:0]    x_in,
   input  logic [7:0]    y_in,
   output logic          pt_valid,
   input  logic          pt_ready,
   output logic [1:0]    pt_tag,
   output logic [8:0]    pt_x,
   output logic [7:0]    pt_y,
   output logic          stroke_active,
   output logic [LW-1:0] fifo_level,
   output logic          overflow,
   input  logic          clear_overflow
);

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ACQUIRE, S_TRACK} state_t;

   state_t             state_q, state_d;
   logic               vs_q, eval_q;
   logic               hit_q;
   logic [8:0]         fx_q, px_q, px_d, tx;
   logic [7:0]         fy_q, py_q, py_d, ty;
   logic [3:0]         acq_q, acq_d, miss_q, miss_d, acq_inc, miss_inc;
   logic               det, cons;
   logic signed [9:0]  dx, dy;
   logic [9:0]         adx, ady;
   logic               push;
   logic [1:0]         push_tag;
   logic [8:0]         push_x;
   logic [7:0]         push_y;

   logic [18:0]        mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wr_q, rd_q;
   logic [LW-1:0]      cnt_q;
   logic               ovf_q, full, pop, wr_en;
   logic [18:0]        head;

   // A strobe on the vsync-rise cycle lands in the latch before evaluation reads it.
   always_ff @(posedge pclk) begin
      if (reset) begin
         vs_q   <= 1'b0;
         eval_q <= 1'b0;
         hit_q  <= 1'b0;
         fx_q   <= '0;
         fy_q   <= '0;
      end else begin
         vs_q   <= vsync;
         eval_q <= vsync & ~vs_q;
         if (ftps_valid) begin
            hit_q <= 1'b1;
            fx_q  <= x_in;
            fy_q  <= y_in;
         end else if (eval_q) begin
            hit_q <= 1'b0;
            fx_q  <= '0;
            fy_q  <= '0;
         end
      end
   end

   assign det = hit_q && (fx_q != '0 || fy_q != '0) &&
                (int'(fx_q) < X_SIZE) && (int'(fy_q) < Y_SIZE);
   assign dx  = $signed({1'b0, fx_q}) - $signed({1'b0, px_q});
   assign dy  = $signed({2'b0, fy_q}) - $signed({2'b0, py_q});
   assign adx = dx[9] ? 10'(-dx) : 10'(dx);
   assign ady = dy[9] ? 10'(-dy) : 10'(dy);
   assign cons = (adx <= 10'(JUMP_MAX)) && (ady <= 10'(JUMP_MAX));

   assign acq_inc  = (acq_q == 4'hF) ? acq_q : acq_q + 4'd1;
   assign miss_inc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

`ifdef FTPS_SMOOTH_EN
   logic [9:0] sum_x, sum_y;
   assign sum_x = {1'b0, px_q} + {1'b0, fx_q};
   assign sum_y = {2'b0, py_q} + {2'b0, fy_q};
   assign tx    = sum_x[9:1];
   assign ty    = sum_y[8:1];
`else
   assign tx = fx_q;
   assign ty = fy_q;
`endif

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acq_q   <= '0;
         miss_q  <= '0;
         px_q    <= '0;
         py_q    <= '0;
      end else begin
         state_q <= state_d;
         acq_q   <= acq_d;
         miss_q  <= miss_d;
         px_q    <= px_d;
         py_q    <= py_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acq_d    = acq_q;
      miss_d   = miss_q;
      px_d     = px_q;
      py_d     = py_q;
      push     = 1'b0;
      push_tag = 2'b00;
      push_x   = px_q;
      push_y   = py_q;
      if (!enable) begin
         if (state_q == S_TRACK) begin
            push     = 1'b1;
            push_tag = 2'b10;
         end
         state_d = S_IDLE;
      end else if (eval_q) begin
         case (state_q)
            S_IDLE:   state_d = S_SEARCH;
            S_SEARCH: begin
               if (det) begin
                  acq_d = 4'd1;
                  px_d  = fx_q;
                  py_d  = fy_q;
                  if (ACQ_FRAMES <= 1) begin
                     state_d  = S_TRACK;
                     miss_d   = '0;
                     push     = 1'b1;
                     push_tag = 2'b01;
                     push_x   = fx_q;
                     push_y   = fy_q;
                  end else begin
                     state_d = S_ACQUIRE;
                  end
               end
            end
            S_ACQUIRE: begin
               if (!det) begin
                  state_d = S_SEARCH;
               end else begin
                  px_d = fx_q;
                  py_d = fy_q;
                  if (!cons) begin
                     acq_d = 4'd1;
                  end else begin
                     acq_d = acq_inc;
                     if (acq_inc >= 4'(ACQ_FRAMES)) begin
                        state_d  = S_TRACK;
                        miss_d   = '0;
                        push     = 1'b1;
                        push_tag = 2'b01;
                        push_x   = fx_q;
                        push_y   = fy_q;
                     end
                  end
               end
            end
            S_TRACK: begin
               if (det && cons) begin
                  push   = 1'b1;
                  push_x = tx;
                  push_y = ty;
                  px_d   = tx;
                  py_d   = ty;
                  miss_d = '0;
               end else begin
                  miss_d = miss_inc;
                  if (miss_inc >= 4'(LOST_FRAMES)) begin
                     push     = 1'b1;
                     push_tag = 2'b10;
                     state_d  = S_SEARCH;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign full  = (cnt_q == LW'(FIFO_DEPTH));
   assign pop   = pt_valid && pt_ready;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge pclk) begin
      if (wr_en) mem_q[wr_q] <= {push_tag, push_x, push_y};
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop)   rd_q <= rd_q + 1'b1;
         if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
         if (clear_overflow)       ovf_q <= 1'b0;
         else if (push && !wr_en)  ovf_q <= 1'b1;
      end
   end

   assign head          = mem_q[rd_q];
   assign pt_valid      = (cnt_q != '0);
   assign pt_tag        = pt_valid ? head[18:17] : 2'b00;
   assign pt_x          = pt_valid ? head[16:8]  : 9'd0;
   assign pt_y          = pt_valid ? head[7:0]   : 8'd0;
   assign stroke_active = (state_q == S_TRACK);
   assign fifo_level    = cnt_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_ftps_stroke_ctrl.sv
// tb/tb_ftps_stroke_ctrl.sv - scoreboard bench for ftps_stroke_ctrl
module tb_ftps_stroke_ctrl;

   logic       pclk = 1'b0, reset = 1'b1, vsync = 1'b0, enable = 1'b0;
   logic       ftps_valid = 1'b0, pt_ready = 1'b0, clear_overflow = 1'b0;
   logic [8:0] x_in = '0;
   logic [7:0] y_in = '0;
   logic       pt_valid, stroke_active, overflow;
   logic [1:0] pt_tag;
   logic [8:0] pt_x;
   logic [7:0] pt_y;
   logic [4:0] fifo_level;

   ftps_stroke_ctrl dut (
      .pclk(pclk), .reset(reset), .vsync(vsync), .enable(enable),
      .ftps_valid(ftps_valid), .x_in(x_in), .y_in(y_in),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_tag(pt_tag),
      .pt_x(pt_x), .pt_y(pt_y), .stroke_active(stroke_active),
      .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow)
   );

   always #5 pclk = ~pclk;

   typedef struct {int tag; int x; int y;} pt_t;
   pt_t exp_q[$];
   pt_t mon_e;
   int  checks = 0, errors = 0;
   int  mode = 0, acq = 0, miss = 0, prevx = 0, prevy = 0;
   bit  exp_ovf = 0, rand_ready = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int absd(int a, int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic void model_push(int tag, int x, int y);
      if (exp_q.size() >= 16) exp_ovf = 1;
      else exp_q.push_back('{tag, x, y});
   endfunction

   // Reference model of the frame rules: modes 0 idle, 1 search, 2 acquire, 3 track.
   function automatic void model_eval(bit has, int x, int y);
      bit det, cons;
      int sx, sy;
      det  = has && !(x == 0 && y == 0) && x < 320 && y < 240;
      cons = det && absd(x, prevx) <= 40 && absd(y, prevy) <= 40;
      sx = x;
      sy = y;
`ifdef FTPS_SMOOTH_EN
      sx = (x + prevx) / 2;
      sy = (y + prevy) / 2;
`endif
      case (mode)
         0: mode = 1;
         1: if (det) begin acq = 1; prevx = x; prevy = y; mode = 2; end
         2: begin
            if (!det) mode = 1;
            else if (cons) begin
               acq++; prevx = x; prevy = y;
               if (acq >= 3) begin mode = 3; miss = 0; model_push(1, x, y); end
            end else begin
               acq = 1; prevx = x; prevy = y;
            end
         end
         default: begin
            if (cons) begin
               model_push(0, sx, sy); prevx = sx; prevy = sy; miss = 0;
            end else begin
               miss++;
               if (miss >= 4) begin model_push(2, prevx, prevy); mode = 1; end
            end
         end
      endcase
   endfunction

   function automatic void model_disable();
      if (mode == 3) model_push(2, prevx, prevy);
      mode = 0;
   endfunction

   always @(negedge pclk) begin
      if (!reset && pt_valid && pt_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_point: got tag %0d x %0d y %0d expected none", pt_tag, pt_x, pt_y);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pt_tag", int'(pt_tag), mon_e.tag);
            chk("pt_x", int'(pt_x), mon_e.x);
            chk("pt_y", int'(pt_y), mon_e.y);
         end
      end
   end

   always @(posedge pclk) begin
      #1;
      if (rand_ready) pt_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #600000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic frame(input bit has, input int x, input int y, input bit at_edge);
      if (has && $urandom_range(0, 1) == 1) begin
         ftps_valid = 1'b1; x_in = 9'($urandom); y_in = 8'($urandom);
         tick();
         ftps_valid = 1'b0;
      end
      repeat (4) tick();
      if (has && !at_edge) begin
         ftps_valid = 1'b1; x_in = 9'(x); y_in = 8'(y);
         tick();
         ftps_valid = 1'b0;
      end
      tick();
      vsync = 1'b1;
      if (has && at_edge) begin
         ftps_valid = 1'b1; x_in = 9'(x); y_in = 8'(y);
      end
      model_eval(has, x, y);
      tick();
      ftps_valid = 1'b0;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (3) tick();
   endtask

   task automatic disable_pulse();
      model_disable();
      enable = 1'b0;
      tick();
      chk("disable_stroke_active", int'(stroke_active), 0);
      tick();
      enable = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && (exp_q.size() != 0 || pt_valid); i++) tick();
      chk("drain_queue_left", exp_q.size(), 0);
      chk("drain_fifo_level", int'(fifo_level), 0);
   endtask

   initial begin
      int r, gx, gy, x, y;
      bit has;
      repeat (3) tick();
      chk("rst_pt_valid", int'(pt_valid), 0);
      chk("rst_stroke_active", int'(stroke_active), 0);
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_pt_xy", int'({pt_tag, pt_x, pt_y}), 0);
      reset = 1'b0;
      tick();

      enable = 1'b1;
      pt_ready = 1'b1;
      frame(0, 0, 0, 0);
      frame(1, 100, 50, 0);
      frame(1, 105, 52, 0);
      frame(1, 110, 55, 0);
      chk("acq_stroke_active", int'(stroke_active), 1);
      frame(1, 110, 55, 0);
      frame(1, 200, 55, 0);
      frame(1, 112, 57, 0);
      frame(1, 113, 58, 1);
      frame(1, 0, 0, 0);
      frame(1, 320, 10, 0);
      frame(0, 0, 0, 0);
      chk("lost_still_active", int'(stroke_active), 1);
      frame(0, 0, 0, 0);
      chk("lost_stroke_active", int'(stroke_active), 0);

      rand_ready = 1;
      gx = 160;
      gy = 120;
      repeat (90) begin
         r = $urandom_range(0, 19);
         has = 1;
         if (r < 13) begin
            gx = gx + $urandom_range(0, 50) - 25;
            gy = gy + $urandom_range(0, 50) - 25;
            if (gx < 1) gx = 1;
            if (gx > 319) gx = 319;
            if (gy < 1) gy = 1;
            if (gy > 239) gy = 239;
            x = gx; y = gy;
         end else if (r < 15) begin
            gx = $urandom_range(1, 319); gy = $urandom_range(1, 239);
            x = gx; y = gy;
         end else if (r < 17) begin
            has = 0; x = 0; y = 0;
         end else if (r == 17) begin
            if ($urandom_range(0, 1) == 1) begin x = 0; y = 0; end
            else begin x = $urandom_range(320, 511); y = gy; end
         end else begin
            has = 0; x = 0; y = 0;
            disable_pulse();
         end
         frame(has, x, y, $urandom_range(0, 3) == 0);
         chk("rand_stroke_active", int'(stroke_active), int'(mode == 3));
      end
      rand_ready = 0;
      pt_ready = 1'b1;
      disable_pulse();
      drain();

      pt_ready = 1'b0;
      frame(0, 0, 0, 0);
      frame(1, 50, 60, 0);
      frame(1, 52, 61, 0);
      frame(1, 54, 62, 0);
      chk("pre_reset_level", int'(fifo_level), 1);
      reset = 1'b1;
      tick();
      chk("midrst_pt_valid", int'(pt_valid), 0);
      chk("midrst_stroke_active", int'(stroke_active), 0);
      chk("midrst_fifo_level", int'(fifo_level), 0);
      chk("midrst_pt_xy", int'({pt_tag, pt_x, pt_y}), 0);
      exp_q.delete();
      mode = 0;
      exp_ovf = 0;
      reset = 1'b0;
      tick();

      frame(0, 0, 0, 0);
      frame(1, 100, 100, 0);
      frame(1, 101, 100, 0);
      frame(1, 102, 100, 0);
      for (int i = 0; i < 16; i++) frame(1, 103 + i, 100, i[0]);
      chk("ovf_fifo_level", int'(fifo_level), 16);
      chk("ovf_flag", int'(overflow), int'(exp_ovf));
      pt_ready = 1'b1;
      drain();
      chk("ovf_sticky", int'(overflow), 1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("ovf_cleared", int'(overflow), 0);
      chk("track_before_disable", int'(stroke_active), 1);
      disable_pulse();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
